// File: rtl/rs_pkg.sv
// ---------------------------------------------------------------------------
// rs_pkg : GF(2^8) constants, Chien state encoding and field helper functions
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rs_pkg;

   // Reduction term of x^8 + x^4 + x^3 + x^2 + 1 (the x^8 bit is implicit)
   localparam logic [7:0] GF_POLY    = 8'h1D;
   localparam logic [7:0] ALPHA_INV1 = 8'h8E;
   localparam logic [7:0] ALPHA_INV2 = 8'h47;
   localparam logic [7:0] ALPHA_INV3 = 8'hAD;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      FIN  = 2'd2
   } state_t;

   // Shift-and-add multiply; with one constant operand it folds to an XOR network
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY : 8'h00);
      end
      return acc;
   endfunction

   function automatic logic [1:0] sigma_deg(input logic [7:0] c1,
                                            input logic [7:0] c2,
                                            input logic [7:0] c3);
      if (c3 != 8'h00) return 2'd3;
      if (c2 != 8'h00) return 2'd2;
      if (c1 != 8'h00) return 2'd1;
      return 2'd0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/chien_search_if.sv
// ---------------------------------------------------------------------------
// chien_search_if : locator-coefficient request and root/summary report bus
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface chien_search_if;
   logic       start;
   logic [7:0] s1;
   logic [7:0] s2;
   logic [7:0] s3;
   logic       busy;
   logic       loc_valid;
   logic [7:0] loc_index;
   logic       done;
   logic [1:0] err_count;
   logic       fail;

   modport master (
      output start, s1, s2, s3,
      input  busy, loc_valid, loc_index, done, err_count, fail
   );

   modport slave (
      input  start, s1, s2, s3,
      output busy, loc_valid, loc_index, done, err_count, fail
   );
endinterface

`default_nettype wire

// File: rtl/chien_search_gf_const_mul.sv
// ---------------------------------------------------------------------------
// gf_const_mul : combinational GF(2^8) multiply by a parameterised constant
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gf_const_mul
   import rs_pkg::*;
#(
   parameter logic [7:0] K = 8'h01
) (
   input  logic [7:0] a,
   output logic [7:0] y
);

   assign y = gf_mul(a, K);

endmodule

`default_nettype wire

// File: rtl/chien_search.sv
// ---------------------------------------------------------------------------
// chien_search : RS(255,249) t=3 Chien root scan, one codeword position per clock
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module chien_search
   import rs_pkg::*;
#(
   parameter int N = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   chien_search_if.slave bus
);

   state_t     state;
   logic [7:0] r1, r2, r3;
   logic [7:0] n1, n2, n3;
   logic [7:0] j;
   logic [1:0] cnt;
   logic [1:0] deg;
   logic       ovf;

   logic       busy_q;
   logic       loc_valid_q;
   logic [7:0] loc_index_q;
   logic       done_q;
   logic [1:0] err_count_q;
   logic       fail_q;

   logic [7:0] eval;
   logic       hit;
   logic       last;
   logic [1:0] cnt_next;
   logic       ovf_next;
   logic [1:0] deg_in;

   gf_const_mul #(.K(ALPHA_INV1)) u_mul1 (.a(r1), .y(n1));
   gf_const_mul #(.K(ALPHA_INV2)) u_mul2 (.a(r2), .y(n2));
   gf_const_mul #(.K(ALPHA_INV3)) u_mul3 (.a(r3), .y(n3));

   // A fourth root can only come from a corrupt locator; remember it so fail sticks
   always_comb begin
      eval     = 8'h01 ^ r1 ^ r2 ^ r3;
      hit      = (eval == 8'h00);
      last     = (j == 8'(N - 1));
      cnt_next = (hit && cnt != 2'd3) ? cnt + 2'd1 : cnt;
      ovf_next = ovf | (hit && cnt == 2'd3);
      deg_in   = sigma_deg(bus.s1, bus.s2, bus.s3);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         r1          <= 8'h00;
         r2          <= 8'h00;
         r3          <= 8'h00;
         j           <= 8'h00;
         cnt         <= 2'd0;
         deg         <= 2'd0;
         ovf         <= 1'b0;
         busy_q      <= 1'b0;
         loc_valid_q <= 1'b0;
         loc_index_q <= 8'h00;
         done_q      <= 1'b0;
         err_count_q <= 2'd0;
         fail_q      <= 1'b0;
      end else begin
         loc_valid_q <= 1'b0;
         done_q      <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  r1          <= bus.s1;
                  r2          <= bus.s2;
                  r3          <= bus.s3;
                  j           <= 8'h00;
                  cnt         <= 2'd0;
                  ovf         <= 1'b0;
                  deg         <= deg_in;
                  busy_q      <= 1'b1;
                  err_count_q <= 2'd0;
                  fail_q      <= 1'b0;
                  state       <= (deg_in == 2'd0) ? FIN : SCAN;
               end
            end
            SCAN: begin
               r1  <= n1;
               r2  <= n2;
               r3  <= n3;
               j   <= j + 8'd1;
               cnt <= cnt_next;
               ovf <= ovf_next;
               if (hit) begin
                  loc_valid_q <= 1'b1;
                  loc_index_q <= j;
               end
               if (last) begin
                  state       <= FIN;
                  done_q      <= 1'b1;
                  err_count_q <= cnt_next;
                  fail_q      <= ovf_next | (cnt_next != deg);
               end
            end
            FIN: begin
               // Arriving straight from IDLE (deg 0) spends one cycle before done
               if (done_q) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  done_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.loc_valid = loc_valid_q;
   assign bus.loc_index = loc_index_q;
   assign bus.done      = done_q;
   assign bus.err_count = err_count_q;
   assign bus.fail      = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_chien_search.sv
// ---------------------------------------------------------------------------
// tb_chien_search : scoreboard bench for chien_search at N=255 and N=20
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_chien_search;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   chien_search_if bus0 ();
   chien_search_if bus1 ();

   chien_search #(.N(255)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   chien_search #(.N(20))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   typedef struct {
      bit         is_done;
      int         cyc;
      logic [7:0] idx;
      logic [1:0] err;
      logic       fl;
   } evt_t;

   evt_t q0[$];
   evt_t q1[$];
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int sel, input bit d, input int c, input logic [7:0] idx,
                       input logic [1:0] e, input logic f);
      evt_t ev;
      ev.is_done = d;
      ev.cyc     = c;
      ev.idx     = idx;
      ev.err     = e;
      ev.fl      = f;
      if (sel == 0) q0.push_back(ev);
      else          q1.push_back(ev);
   endtask

   function automatic int qsize(input int sel);
      if (sel == 0) return q0.size();
      return q1.size();
   endfunction

   function automatic evt_t qfront(input int sel);
      if (sel == 0) return q0[0];
      return q1[0];
   endfunction

   task automatic qpop(input int sel);
      if (sel == 0) void'(q0.pop_front());
      else          void'(q1.pop_front());
   endtask

   task automatic observe(input int sel, input logic lv, input logic [7:0] li,
                          input logic dn, input logic [1:0] ec, input logic fl);
      evt_t ev;
      while (qsize(sel) > 0 && qfront(sel).cyc < cyc) begin
         ev = qfront(sel);
         qpop(sel);
         n_cmp++;
         n_fail++;
         $display("FAIL dut%0d missed %s: expected at cycle %0d, it did not occur", sel,
                  ev.is_done ? "done" : "loc_valid", ev.cyc);
      end
      if (lv === 1'b1) begin
         n_cmp++;
         if (qsize(sel) == 0) begin
            n_fail++;
            $display("FAIL dut%0d unexpected loc_valid: got index %0d at cycle %0d, expected none",
                     sel, li, cyc);
         end else begin
            ev = qfront(sel);
            qpop(sel);
            if (ev.is_done || ev.cyc != cyc || ev.idx !== li) begin
               n_fail++;
               $display("FAIL dut%0d loc_valid: got index %0d at cycle %0d, expected %s index %0d at cycle %0d",
                        sel, li, cyc, ev.is_done ? "done" : "loc", ev.idx, ev.cyc);
            end
         end
      end
      if (dn === 1'b1) begin
         n_cmp++;
         if (qsize(sel) == 0) begin
            n_fail++;
            $display("FAIL dut%0d unexpected done at cycle %0d, expected none", sel, cyc);
         end else begin
            ev = qfront(sel);
            qpop(sel);
            if (!ev.is_done || ev.cyc != cyc || ev.err !== ec || ev.fl !== fl) begin
               n_fail++;
               $display("FAIL dut%0d done: got err_count=%0d fail=%0d at cycle %0d, expected %s err_count=%0d fail=%0d at cycle %0d",
                        sel, ec, fl, cyc, ev.is_done ? "done" : "loc", ev.err, ev.fl, ev.cyc);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      observe(0, bus0.loc_valid, bus0.loc_index, bus0.done, bus0.err_count, bus0.fail);
      observe(1, bus1.loc_valid, bus1.loc_index, bus1.done, bus1.err_count, bus1.fail);
   end

   task automatic at_cycle(input int t);
      do @(negedge clk); while (cyc < t);
   endtask

   // Returns c0 = value of cyc seen at the negedge right after the start edge
   task automatic start_run(input int sel, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, output int c0);
      @(negedge clk);
      c0 = cyc + 1;
      if (sel == 0) begin
         bus0.start = 1'b1; bus0.s1 = a; bus0.s2 = b; bus0.s3 = c;
      end else begin
         bus1.start = 1'b1; bus1.s1 = a; bus1.s2 = b; bus1.s3 = c;
      end
      @(posedge clk);
      #1;
      bus0.start = 1'b0; bus0.s1 = 8'hA5; bus0.s2 = 8'h5A; bus0.s3 = 8'hC3;
      bus1.start = 1'b0; bus1.s1 = 8'hA5; bus1.s2 = 8'h5A; bus1.s3 = 8'hC3;
   endtask

   task automatic chk_zero(input string tag, input logic b, input logic lv, input logic [7:0] li,
                           input logic dn, input logic [1:0] ec, input logic fl);
      chk({tag, " busy"},      32'(b),  32'd0);
      chk({tag, " loc_valid"}, 32'(lv), 32'd0);
      chk({tag, " loc_index"}, 32'(li), 32'd0);
      chk({tag, " done"},      32'(dn), 32'd0);
      chk({tag, " err_count"}, 32'(ec), 32'd0);
      chk({tag, " fail"},      32'(fl), 32'd0);
   endtask

   initial begin
      int c0;
      bus0.start = 1'b0; bus0.s1 = 8'h00; bus0.s2 = 8'h00; bus0.s3 = 8'h00;
      bus1.start = 1'b0; bus1.s1 = 8'h00; bus1.s2 = 8'h00; bus1.s3 = 8'h00;

      @(negedge clk);
      chk_zero("reset dut0", bus0.busy, bus0.loc_valid, bus0.loc_index, bus0.done, bus0.err_count, bus0.fail);
      chk_zero("reset dut1", bus1.busy, bus1.loc_valid, bus1.loc_index, bus1.done, bus1.err_count, bus1.fail);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // sigma = 1 + alpha^5 x : single root at position 5
      start_run(0, 8'h20, 8'h00, 8'h00, c0);
      push(0, 0, c0 + 6, 8'd5, 2'd0, 1'b0);
      push(0, 1, c0 + 255, 8'd0, 2'd1, 1'b0);
      at_cycle(c0);
      chk("busy after E0", 32'(bus0.busy), 32'd1);
      at_cycle(c0 + 255);
      chk("busy in done cycle", 32'(bus0.busy), 32'd1);
      bus0.start = 1'b1; bus0.s1 = 8'h07; bus0.s2 = 8'h0E; bus0.s3 = 8'h08;
      at_cycle(c0 + 256);
      bus0.start = 1'b0;
      chk("busy after FIN, start in done cycle ignored", 32'(bus0.busy), 32'd0);
      at_cycle(c0 + 260);

      // Roots at positions 0,1,2
      start_run(0, 8'h07, 8'h0E, 8'h08, c0);
      push(0, 0, c0 + 1, 8'd0, 2'd0, 1'b0);
      push(0, 0, c0 + 2, 8'd1, 2'd0, 1'b0);
      push(0, 0, c0 + 3, 8'd2, 2'd0, 1'b0);
      push(0, 1, c0 + 255, 8'd0, 2'd3, 1'b0);
      at_cycle(c0 + 258);
      chk("err_count holds after done", 32'(bus0.err_count), 32'd3);

      // sigma = (1+x)^2 : one distinct root, degree 2
      start_run(0, 8'h00, 8'h01, 8'h00, c0);
      push(0, 0, c0 + 1, 8'd0, 2'd0, 1'b0);
      push(0, 1, c0 + 255, 8'd0, 2'd1, 1'b1);
      at_cycle(c0 + 258);

      // Degree 0
      start_run(0, 8'h00, 8'h00, 8'h00, c0);
      push(0, 1, c0 + 1, 8'd0, 2'd0, 1'b0);
      at_cycle(c0);
      chk("deg0 busy at E0+", 32'(bus0.busy), 32'd1);
      at_cycle(c0 + 1);
      chk("deg0 busy in done cycle", 32'(bus0.busy), 32'd1);
      at_cycle(c0 + 2);
      chk("deg0 busy low after", 32'(bus0.busy), 32'd0);
      at_cycle(c0 + 4);

      // Root at the last position j = N-1 = 254, coincident with done
      start_run(0, 8'h8E, 8'h00, 8'h00, c0);
      push(0, 0, c0 + 255, 8'd254, 2'd0, 1'b0);
      push(0, 1, c0 + 255, 8'd0, 2'd1, 1'b0);
      at_cycle(c0 + 258);

      // Shortened code N=20
      start_run(1, 8'h20, 8'h00, 8'h00, c0);
      push(1, 0, c0 + 6, 8'd5, 2'd0, 1'b0);
      push(1, 1, c0 + 20, 8'd0, 2'd1, 1'b0);
      at_cycle(c0 + 23);
      start_run(1, 8'h60, 8'h00, 8'h00, c0);
      push(1, 1, c0 + 20, 8'd0, 2'd0, 1'b1);
      at_cycle(c0 + 23);
      chk("N20 fail holds", 32'(bus1.fail), 32'd1);
      start_run(1, 8'h5A, 8'h00, 8'h00, c0);
      push(1, 0, c0 + 20, 8'd19, 2'd0, 1'b0);
      push(1, 1, c0 + 20, 8'd0, 2'd1, 1'b0);
      at_cycle(c0 + 23);

      // Start during busy is ignored, then reset at E100 aborts the scan
      start_run(0, 8'h20, 8'h00, 8'h00, c0);
      push(0, 0, c0 + 6, 8'd5, 2'd0, 1'b0);
      at_cycle(c0 + 50);
      bus0.start = 1'b1; bus0.s1 = 8'h07; bus0.s2 = 8'h0E; bus0.s3 = 8'h08;
      at_cycle(c0 + 51);
      bus0.start = 1'b0;
      at_cycle(c0 + 99);
      chk("busy before abort", 32'(bus0.busy), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk_zero("async reset", bus0.busy, bus0.loc_valid, bus0.loc_index, bus0.done, bus0.err_count, bus0.fail);
      at_cycle(c0 + 102);
      rst_n = 1'b1;
      at_cycle(c0 + 400);
      chk("idle after abort", 32'(bus0.busy), 32'd0);

      chk("dut0 pending events", 32'(q0.size()), 32'd0);
      chk("dut1 pending events", 32'(q1.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
